// File: rtl/fifo_packetizer_if.sv
// Purpose : groups the FIFO drain side and the framed byte-stream side of fifo_packetizer.
// Latency : n/a (signal bundle only).
// Backpressure: out_ready from the slave side stalls the stream; fifo_empty gates reads.
// Signals : fifo_empty/fifo_data/fifo_rd_en (upstream FIFO), out_data/out_valid/out_ready/
//           out_last (downstream stream), busy (status).
// Modports: master = packetizer view, slave = environment (FIFO + stream sink) view.
interface fifo_packetizer_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_rd_en, out_data, out_valid, out_last, busy
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/fifo_packetizer.sv
// Purpose : drains a 1-cycle-latency FIFO into a payload store and emits SOF,LEN,payload,CHK frames.
// Latency : frame starts 2 cycles after the last capture when full, TIMEOUT+2 after it on idle flush.
// Backpressure: out_ready low holds out_data/out_last; no FIFO reads happen while a frame is sent.
// Ports   : clk, rst (async, active-high), io_pkt (fifo_packetizer_if.master).
// Option  : define PKT_CRC8_EN to make CHK a CRC-8 (poly 0x07, init 0) instead of the mod-256 sum.
module fifo_packetizer #(
    parameter int         MAX_PAYLOAD = 16,
    parameter int         TIMEOUT     = 32,
    parameter logic [7:0] SOF_BYTE    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    fifo_packetizer_if.master  io_pkt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_SEND_SOF,
        ST_SEND_LEN,
        ST_SEND_DATA,
        ST_SEND_CHK
    } state_t;

    state_t         r_state;
    logic [7:0]     r_count;
    logic [TW-1:0]  r_timer;
    logic           r_rd_pending;
    logic [7:0]     r_idx;
    logic [7:0]     r_chk;
    logic [7:0]     r_out_data;
    logic           r_out_valid;
    logic           r_out_last;
    logic [7:0]     r_payload [0:MAX_PAYLOAD-1];

    logic [8:0]     w_fill;
    logic           w_full;
    logic           w_timeout;
    logic           w_exit;
    logic           w_rd_en;
    logic           w_xfer;
    logic           w_capture;
    logic [7:0]     w_chk_next;
    logic [7:0]     w_idx_nxt;

    // One checksum step over a byte that is being transferred.
    function automatic logic [7:0] chk_update(input logic [7:0] c, input logic [7:0] b);
`ifdef PKT_CRC8_EN
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
`else
        return c + b;
`endif
    endfunction

    // Bytes in hand plus the one in flight must stay within the payload store.
    assign w_fill    = {1'b0, r_count} + {8'd0, r_rd_pending};
    assign w_full    = (r_count == 8'(MAX_PAYLOAD));
    assign w_timeout = (r_timer == TW'(TIMEOUT)) && (r_count != 8'd0);
    // Leave COLLECT only with nothing in flight so no FIFO byte is dropped.
    assign w_exit    = (r_state == ST_COLLECT) && !r_rd_pending && (w_full || w_timeout);
    assign w_rd_en   = (r_state == ST_COLLECT) && !w_exit && !io_pkt.fifo_empty &&
                       (w_fill < 9'(MAX_PAYLOAD));
    assign w_capture = (r_state == ST_COLLECT) && r_rd_pending;
    assign w_xfer    = r_out_valid && io_pkt.out_ready;
    // LEN and payload bytes fold into the check as they leave.
    assign w_chk_next = chk_update(r_chk, r_out_data);
    assign w_idx_nxt  = r_idx + 8'd1;

    assign io_pkt.fifo_rd_en = w_rd_en;
    assign io_pkt.out_data   = r_out_data;
    assign io_pkt.out_valid  = r_out_valid;
    assign io_pkt.out_last   = r_out_last;
    assign io_pkt.busy       = !((r_state == ST_COLLECT) && (r_count == 8'd0));

    // Payload store carries no reset; count says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_payload[r_count[IW-1:0]] <= io_pkt.fifo_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_COLLECT;
            r_count      <= 8'd0;
            r_timer      <= '0;
            r_rd_pending <= 1'b0;
            r_idx        <= 8'd0;
            r_chk        <= 8'd0;
            r_out_data   <= 8'h00;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_rd_pending <= w_rd_en;
            case (r_state)
                ST_COLLECT: begin
                    if (r_rd_pending) begin
                        r_count <= r_count + 8'd1;
                    end
                    if (r_rd_pending || w_rd_en) begin
                        r_timer <= '0;
                    end else if (r_count != 8'd0) begin
                        r_timer <= r_timer + TW'(1);
                    end
                    if (w_exit) begin
                        r_state     <= ST_SEND_SOF;
                        r_out_valid <= 1'b1;
                        r_out_data  <= SOF_BYTE;
                        r_out_last  <= 1'b0;
                        r_chk       <= 8'd0;
                    end
                end
                ST_SEND_SOF: begin
                    if (w_xfer) begin
                        r_out_data <= r_count;
                        r_state    <= ST_SEND_LEN;
                    end
                end
                ST_SEND_LEN: begin
                    if (w_xfer) begin
                        r_chk      <= w_chk_next;
                        r_out_data <= r_payload[0];
                        r_idx      <= 8'd0;
                        r_state    <= ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (w_xfer) begin
                        r_chk <= w_chk_next;
                        if (r_idx == r_count - 8'd1) begin
                            // Check byte already includes the final payload byte.
                            r_out_data <= w_chk_next;
                            r_out_last <= 1'b1;
                            r_state    <= ST_SEND_CHK;
                        end else begin
                            r_out_data <= r_payload[w_idx_nxt[IW-1:0]];
                            r_idx      <= w_idx_nxt;
                        end
                    end
                end
                ST_SEND_CHK: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_out_data  <= 8'h00;
                        r_count     <= 8'd0;
                        r_timer     <= '0;
                        r_chk       <= 8'd0;
                        r_state     <= ST_COLLECT;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_packetizer.sv
module tb_fifo_packetizer;
    localparam int MAXP = 16;
    localparam int TO   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_packetizer_if pif ();

    fifo_packetizer #(.MAX_PAYLOAD(MAXP), .TIMEOUT(TO), .SOF_BYTE(8'hA5)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_pkt (pif)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] fifo_q [$];
    logic [7:0] stage_q [$];
    logic [8:0] exp_q [$];     // {last, data}
    int         exp_lat [$];   // cycles from last FIFO pop to frame start

    int   ready_mode = 0;      // 0: always ready, 1: random, 2: pattern 1,0,0,1
    int   ready_phase = 0;
    int   last_pop_cyc = 0;
    logic take = 1'b0;

    always @(posedge clk) cyc++;

    // Ring-buffer model: rd_en seen during a cycle yields data and an updated empty flag after the edge.
    always @(negedge clk) take = pif.fifo_rd_en;

    always @(posedge clk) begin
        #1;
        if (take && !rst) begin
            tests++;
            if (fifo_q.size() == 0) begin
                fails++;
                $display("FAIL rd_on_empty: read strobe with FIFO empty at cycle %0d", cyc);
            end else begin
                pif.fifo_data = fifo_q.pop_front();
                last_pop_cyc  = cyc;
            end
        end
        take = 1'b0;
        pif.fifo_empty = (fifo_q.size() == 0);
        case (ready_mode)
            0: pif.out_ready = 1'b1;
            1: pif.out_ready = 1'($urandom_range(0, 1));
            default: begin
                pif.out_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                ready_phase++;
            end
        endcase
    end

    // Frame check value computed bit-serially over LEN then payload.
    function automatic logic [7:0] model_chk(input int len, input int off);
        logic [7:0] msg [$];
        int s;
        logic [7:0] crc;
        logic fb;
        msg.push_back(8'(len));
        for (int i = 0; i < len; i++) msg.push_back(stage_q[off + i]);
        s = 0;
        crc = 8'h00;
        foreach (msg[k]) begin
            s = s + int'(msg[k]);
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[7] ^ msg[k][b];
                crc = {crc[6:0], 1'b0};
                if (fb) crc = crc ^ 8'h07;
            end
        end
`ifdef PKT_CRC8_EN
        return crc;
`else
        return 8'(s % 256);
`endif
    endfunction

    // Push stage_q into the FIFO and predict the frames it must produce.
    task automatic load_fifo();
        int off;
        int len;
        off = 0;
        while (off < stage_q.size()) begin
            len = stage_q.size() - off;
            if (len > MAXP) len = MAXP;
            exp_q.push_back({1'b0, 8'hA5});
            exp_q.push_back({1'b0, 8'(len)});
            for (int i = 0; i < len; i++) exp_q.push_back({1'b0, stage_q[off + i]});
            exp_q.push_back({1'b1, model_chk(len, off)});
            // Full frames leave right after the last capture; short ones wait out TIMEOUT idle cycles.
            exp_lat.push_back((len == MAXP) ? 2 : TO + 2);
            off += len;
        end
        foreach (stage_q[i]) fifo_q.push_back(stage_q[i]);
        stage_q.delete();
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %02h, expected %02h", name, act, req);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || pif.out_valid || pif.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL %s_timeout: %0d bytes still expected after %0d cycles", name, exp_q.size(), n);
            exp_q.delete();
            exp_lat.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    // Monitor: consumes expected bytes on each transfer, checks stall hold and frame timing.
    logic       prev_valid = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    int         pkt_start  = 0;
    int         nx         = 0;
    logic [8:0] e;
    int         lat;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (pif.out_valid) begin
                tests++;
                if (pif.fifo_rd_en) begin
                    fails++;
                    $display("FAIL rd_during_send: rd_en=1 while out_valid=1 at cycle %0d", cyc);
                end
            end
            if (prev_stall) begin
                tests++;
                if (!pif.out_valid || pif.out_data !== prev_data || pif.out_last !== prev_last) begin
                    fails++;
                    $display("FAIL hold: got v=%0b d=%02h l=%0b, expected v=1 d=%02h l=%0b",
                             pif.out_valid, pif.out_data, pif.out_last, prev_data, prev_last);
                end
            end
            if (pif.out_valid && !prev_valid) begin
                pkt_start = cyc;
                nx = 0;
                tests++;
                if (exp_lat.size() == 0) begin
                    fails++;
                    $display("FAIL start: unexpected frame start at cycle %0d, expected none", cyc);
                end else begin
                    lat = exp_lat.pop_front();
                    if (cyc - last_pop_cyc != lat) begin
                        fails++;
                        $display("FAIL start_latency: got %0d cycles after last pop, expected %0d",
                                 cyc - last_pop_cyc, lat);
                    end
                end
            end
            if (pif.out_valid && pif.out_ready) begin
                nx++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL stream: unexpected byte %02h last=%0b, expected no transfer",
                             pif.out_data, pif.out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({pif.out_last, pif.out_data} !== e) begin
                        fails++;
                        $display("FAIL stream: got last=%0b data=%02h, expected last=%0b data=%02h",
                                 pif.out_last, pif.out_data, e[8], e[7:0]);
                    end
                end
                if (pif.out_last && ready_mode == 0) begin
                    tests++;
                    if (cyc - pkt_start != nx - 1) begin
                        fails++;
                        $display("FAIL zero_bubble: %0d transfers took %0d cycles, expected %0d",
                                 nx, cyc - pkt_start + 1, nx);
                    end
                end
            end
            prev_valid = pif.out_valid;
            prev_stall = pif.out_valid && !pif.out_ready;
            prev_data  = pif.out_data;
            prev_last  = pif.out_last;
        end
    end

    initial begin
        int n;
        pif.fifo_empty = 1'b1;
        pif.fifo_data  = 8'h00;
        pif.out_ready  = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #3;
        check("reset_rd_en",     8'(pif.fifo_rd_en), 8'h00);
        check("reset_out_valid", 8'(pif.out_valid),  8'h00);
        check("reset_out_last",  8'(pif.out_last),   8'h00);
        check("reset_out_data",  pif.out_data,       8'h00);
        check("reset_busy",      8'(pif.busy),       8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Empty FIFO with nothing held: no frame may appear.
        repeat (80) @(negedge clk);
        check("idle_busy", 8'(pif.busy), 8'h00);

        // Full frame, always ready: A5,10,00..0F,88 back-to-back.
        ready_mode = 0;
        for (int i = 0; i < 16; i++) stage_q.push_back(8'(i));
        load_fifo();
        wait_idle("full");

        // Short frame flushed by the idle timer.
        stage_q.push_back(8'h01); stage_q.push_back(8'h02); stage_q.push_back(8'h03);
        load_fifo();
        wait_idle("timeout");

        // Backpressure 1,0,0,1 on a full frame.
        ready_mode = 2;
        ready_phase = 0;
        for (int i = 0; i < 16; i++) stage_q.push_back(8'($urandom_range(0, 255)));
        load_fifo();
        wait_idle("backpressure");

        // 20 preloaded bytes: one full frame then a 4-byte flush.
        ready_mode = 0;
        for (int i = 0; i < 20; i++) stage_q.push_back(8'(8'h40 + i));
        load_fifo();
        wait_idle("overflow");

        // Single zero byte (sum gives 01, CRC-8 gives 15).
        stage_q.push_back(8'h00);
        load_fifo();
        wait_idle("single");

        // Random bursts with random downstream readiness.
        ready_mode = 1;
        for (int b = 0; b < 10; b++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) stage_q.push_back(8'($urandom_range(0, 255)));
            load_fifo();
            wait_idle("random");
        end

        // Reset during payload transmission.
        ready_mode = 2;
        ready_phase = 0;
        for (int i = 0; i < 16; i++) stage_q.push_back(8'($urandom_range(0, 255)));
        load_fifo();
        n = 0;
        while (exp_q.size() > 15 && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 500) begin
            fails++;
            $display("FAIL reset_mid_send_reach: %0d bytes pending, expected at most 15", exp_q.size());
        end
        #2 rst = 1'b1;
        exp_q.delete();
        exp_lat.delete();
        fifo_q.delete();
        #1;
        check("rst_mid_out_valid", 8'(pif.out_valid),  8'h00);
        check("rst_mid_out_last",  8'(pif.out_last),   8'h00);
        check("rst_mid_out_data",  pif.out_data,       8'h00);
        check("rst_mid_rd_en",     8'(pif.fifo_rd_en), 8'h00);
        check("rst_mid_busy",      8'(pif.busy),       8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("post_reset_busy",  8'(pif.busy),      8'h00);
        check("post_reset_valid", 8'(pif.out_valid), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
